mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Memory controller between the byte-wide main RAM port and two requesters: LS_EX (load/store unit) and the instruction fetcher.
//  Latches one-cycle request pulses, arbitrates (LS over IF) and serialises 1/2/4-byte little-endian accesses onto the 8-bit RAM bus.
//  Returns one-cycle ok pulses with assembled data, and respects the I/O buffer-full stall and ROB rollback.
// PARAMETERS
//  ADDR_W   32        address width
//  IO_PORT  32'h30000 first I/O-mapped address; addr[17:16]==2'b11 marks I/O (write stall applies)
// PORTS
//  clk               in  1   clock
//  rst               in  1   synchronous reset, active-low
//  rdy               in  1   global ready; 0 = freeze
//  io_buffer_full    in  1   UART buffer full
//  mem_din           in  8   RAM read byte (valid cycle after its address)
//  mem_dout          out 8   RAM write byte
//  mem_a             out 32  RAM byte address
//  mem_wr            out 1   1 = write
//  ena_from_ls       in  1   LS request pulse
//  addr_from_ls      in  32  LS address
//  data_from_ls      in  32  LS store data
//  wr_flag_from_ls   in  1   1 = write
//  size_from_ls      in  3   bytes: 1, 2 or 4
//  ok_to_ls          out 1   LS done pulse
//  data_to_ls        out 32  load data, zero-extended above size
//  ena_from_if       in  1   fetch request pulse (always 4-byte read)
//  addr_from_if      in  32  fetch address
//  ok_to_if          out 1   fetch done pulse
//  inst_to_if        out 32  fetched word
//  rollback_flag     in  1   ROB rollback
// BEHAVIOUR
//  Reset (rst==0 at edge): mem_wr=0, mem_a=0, mem_dout=0, ok_to_ls=ok_to_if=0, data_to_ls=inst_to_if=0, state IDLE, pending slots cleared.
//  rdy==0: all registers hold; mem_wr forced 0; request pulses arriving during that cycle are dropped.
//  Pending: one LS slot, one IF slot; pulse loads slot; re-pulse to an occupied slot overwrites it.
//  States IDLE, READ, WRITE. IDLE picks LS slot, else IF slot, clears it, loads addr/size/data, byte counter=0.
//  Request in IDLE with empty slots starts same edge (slot bypass); ok pulses are always one cycle, registered.
//  READ N bytes, start edge T: mem_a=addr+i in cycles T+1..T+N, mem_wr=0; byte i captured at edge T+2+i into bits [8i+7:8i];
//   ok asserted cycle T+N+2 with data; upper bytes zero (sign-extension is LS_EX's job).
//  WRITE N bytes: cycles T+1..T+N drive mem_a=addr+i, mem_dout=data[8i+7:8i], mem_wr=1; ok_to_ls in cycle T+N+1.
//  I/O write with io_buffer_full=1: mem_wr=0, counter holds, address unchanged, until flag drops; ok delayed by stall count.
//  Address adder wraps mod 2^32; no alignment check.
//  rollback_flag=1: in-progress READ (LS or IF) aborts, IDLE next edge, no ok; both read slots cleared;
//   in-progress WRITE completes and acks; pending LS write slot kept. Rollback same cycle as ok: ok still issued.
//  Simultaneous LS and IF pulses in IDLE: LS starts, IF waits in slot; back-to-back ops have one IDLE cycle between.
//  Mid-operation reset: abort immediately, no ok, mem_wr=0 next cycle.
// TESTING
//  LW 0x100, RAM 0x100..0x103=11 22 33 44 -> ok_to_ls cycle T+6, data_to_ls=0x44332211.
//  SH 0x200 data 0xDEADBEEF -> two mem_wr cycles, bytes EF@0x200, BE@0x201, ok_to_ls T+3.
//  SB 0x30000 with io_buffer_full high 3 cycles -> mem_wr held 0 for 3, ok_to_ls at T+5.
//  LS LB 0x10 and IF 0x0 same cycle -> LS ok first; IF ok after one IDLE cycle + 6.
//  IF read, rollback at T+3 -> no ok_to_if, IDLE at T+4; rollback during SW -> write completes, ok.
//  rdy low 2 cycles mid LW -> ok delayed exactly 2 cycles, data correct; rst low mid-op -> outputs all 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates load/store and fetch requests onto the byte-wide RAM.
// Accesses of 1/2/4 bytes are serialised little-endian, one byte per cycle.
module mem_ctrl #(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_PORT = 32'h30000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              ena_from_ls,
    input  logic [ADDR_W-1:0] addr_from_ls,
    input  logic [31:0]       data_from_ls,
    input  logic              wr_flag_from_ls,
    input  logic [2:0]        size_from_ls,
    output logic              ok_to_ls,
    output logic [31:0]       data_to_ls,
    input  logic              ena_from_if,
    input  logic [ADDR_W-1:0] addr_from_if,
    output logic              ok_to_if,
    output logic [31:0]       inst_to_if,
    input  logic              rollback_flag
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state_q, state_d;
    logic              ls_v_q, ls_v_d;
    logic [ADDR_W-1:0] ls_addr_q, ls_addr_d;
    logic [31:0]       ls_data_q, ls_data_d;
    logic              ls_wr_q, ls_wr_d;
    logic [2:0]        ls_size_q, ls_size_d;
    logic              if_v_q, if_v_d;
    logic [ADDR_W-1:0] if_addr_q, if_addr_d;
    logic [ADDR_W-1:0] op_addr_q, op_addr_d;
    logic [31:0]       op_data_q, op_data_d;
    logic [2:0]        op_size_q, op_size_d;
    logic              op_if_q, op_if_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        rx_q, rx_d;
    logic              rd_bus_q, rd_bus_d;
    logic              din_v_q, din_v_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              ok_ls_q, ok_ls_d;
    logic              ok_if_q, ok_if_d;
    logic [31:0]       data_ls_q, data_ls_d;
    logic [31:0]       inst_q, inst_d;
    logic              start, st_wr, stall;

    // I/O writes stall while the UART buffer is full
    assign stall = (state_q == WRITE) && io_buffer_full &&
                   (op_addr_q[17:16] == IO_PORT[17:16]);

    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign mem_wr     = mem_wr_q & rdy & ~stall;
    assign ok_to_ls   = ok_ls_q;
    assign ok_to_if   = ok_if_q;
    assign data_to_ls = data_ls_q;
    assign inst_to_if = inst_q;

    always_comb begin
        state_d    = state_q;
        op_addr_d  = op_addr_q;
        op_data_d  = op_data_q;
        op_size_d  = op_size_q;
        op_if_d    = op_if_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        rd_bus_d   = rd_bus_q;
        din_v_d    = din_v_q;
        rdata_d    = rdata_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        data_ls_d  = data_ls_q;
        inst_d     = inst_q;
        ok_ls_d    = 1'b0;
        ok_if_d    = 1'b0;
        start      = 1'b0;
        st_wr      = 1'b0;

        // a new pulse overwrites its slot and is visible to IDLE at once
        ls_v_d    = ena_from_ls | ls_v_q;
        ls_addr_d = ena_from_ls ? addr_from_ls : ls_addr_q;
        ls_data_d = ena_from_ls ? data_from_ls : ls_data_q;
        ls_wr_d   = ena_from_ls ? wr_flag_from_ls : ls_wr_q;
        ls_size_d = ena_from_ls ? size_from_ls : ls_size_q;
        if_v_d    = ena_from_if | if_v_q;
        if_addr_d = ena_from_if ? addr_from_if : if_addr_q;

        if (rollback_flag) begin
            if (!ls_wr_d) ls_v_d = 1'b0;
            if_v_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (ls_v_d) begin
                    ls_v_d    = 1'b0;
                    start     = 1'b1;
                    st_wr     = ls_wr_d;
                    op_if_d   = 1'b0;
                    op_addr_d = ls_addr_d;
                    op_data_d = ls_data_d;
                    op_size_d = ls_size_d;
                end else if (if_v_d) begin
                    if_v_d    = 1'b0;
                    start     = 1'b1;
                    op_if_d   = 1'b1;
                    op_addr_d = if_addr_d;
                    op_size_d = 3'd4;
                end
                if (start) begin
                    cnt_d   = 3'd1;
                    rx_d    = 3'd0;
                    rdata_d = 32'd0;
                    din_v_d = 1'b0;
                    mem_a_d = op_addr_d;
                    if (st_wr) begin
                        state_d    = WRITE;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = op_data_d[7:0];
                    end else begin
                        state_d  = READ;
                        rd_bus_d = 1'b1;
                    end
                end
            end
            READ: begin
                din_v_d  = rd_bus_q;
                rd_bus_d = cnt_q < op_size_q;
                if (rd_bus_d) begin
                    mem_a_d = op_addr_q + ADDR_W'(cnt_q);
                    cnt_d   = cnt_q + 3'd1;
                end
                if (din_v_q) begin
                    rdata_d = rdata_q | (32'(mem_din) << {rx_q, 3'b000});
                    rx_d    = rx_q + 3'd1;
                    if (rx_q == op_size_q - 3'd1) begin
                        state_d  = IDLE;
                        rd_bus_d = 1'b0;
                        din_v_d  = 1'b0;
                        if (op_if_q) begin
                            ok_if_d = 1'b1;
                            inst_d  = rdata_d;
                        end else begin
                            ok_ls_d   = 1'b1;
                            data_ls_d = rdata_d;
                        end
                    end
                end
                // a squashed read stops where it is and reports nothing
                if (rollback_flag) begin
                    state_d   = IDLE;
                    rd_bus_d  = 1'b0;
                    din_v_d   = 1'b0;
                    mem_a_d   = mem_a_q;
                    ok_ls_d   = 1'b0;
                    ok_if_d   = 1'b0;
                    data_ls_d = data_ls_q;
                    inst_d    = inst_q;
                end
            end
            WRITE: begin
                if (!stall) begin
                    if (cnt_q == op_size_q) begin
                        state_d  = IDLE;
                        mem_wr_d = 1'b0;
                        ok_ls_d  = 1'b1;
                    end else begin
                        mem_a_d    = op_addr_q + ADDR_W'(cnt_q);
                        mem_dout_d = 8'(op_data_q >> {cnt_q, 3'b000});
                        cnt_d      = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ls_v_q     <= 1'b0;
            ls_addr_q  <= '0;
            ls_data_q  <= '0;
            ls_wr_q    <= 1'b0;
            ls_size_q  <= '0;
            if_v_q     <= 1'b0;
            if_addr_q  <= '0;
            op_addr_q  <= '0;
            op_data_q  <= '0;
            op_size_q  <= '0;
            op_if_q    <= 1'b0;
            cnt_q      <= '0;
            rx_q       <= '0;
            rd_bus_q   <= 1'b0;
            din_v_q    <= 1'b0;
            rdata_q    <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            ok_ls_q    <= 1'b0;
            ok_if_q    <= 1'b0;
            data_ls_q  <= '0;
            inst_q     <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            ls_v_q     <= ls_v_d;
            ls_addr_q  <= ls_addr_d;
            ls_data_q  <= ls_data_d;
            ls_wr_q    <= ls_wr_d;
            ls_size_q  <= ls_size_d;
            if_v_q     <= if_v_d;
            if_addr_q  <= if_addr_d;
            op_addr_q  <= op_addr_d;
            op_data_q  <= op_data_d;
            op_size_q  <= op_size_d;
            op_if_q    <= op_if_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            rd_bus_q   <= rd_bus_d;
            din_v_q    <= din_v_d;
            rdata_q    <= rdata_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            ok_ls_q    <= ok_ls_d;
            ok_if_q    <= ok_if_d;
            data_ls_q  <= data_ls_d;
            inst_q     <= inst_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vectors for mem_ctrl against a small byte RAM model.
// Latencies are counted in cycles after the request's start edge.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        ena_from_ls, wr_flag_from_ls;
    logic [31:0] addr_from_ls, data_from_ls;
    logic [2:0]  size_from_ls;
    logic        ok_to_ls;
    logic [31:0] data_to_ls;
    logic        ena_from_if;
    logic [31:0] addr_from_if;
    logic        ok_to_if;
    logic [31:0] inst_to_if;
    logic        rollback_flag;

    logic [7:0]  ram [0:1023];
    logic [7:0]  io_last;
    int          n_chk = 0;
    int          n_fail = 0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .ena_from_ls(ena_from_ls), .addr_from_ls(addr_from_ls),
        .data_from_ls(data_from_ls), .wr_flag_from_ls(wr_flag_from_ls),
        .size_from_ls(size_from_ls), .ok_to_ls(ok_to_ls), .data_to_ls(data_to_ls),
        .ena_from_if(ena_from_if), .addr_from_if(addr_from_if),
        .ok_to_if(ok_to_if), .inst_to_if(inst_to_if),
        .rollback_flag(rollback_flag)
    );

    always #5 clk = ~clk;

    // RAM: registered read one cycle after the address, frozen with rdy
    always @(posedge clk) begin
        if (!rst) begin
            ram[10'h100] <= 8'h11;
            ram[10'h101] <= 8'h22;
            ram[10'h102] <= 8'h33;
            ram[10'h103] <= 8'h44;
            ram[10'h010] <= 8'h5A;
            ram[10'h000] <= 8'h13;
            ram[10'h001] <= 8'h05;
            ram[10'h002] <= 8'h50;
            ram[10'h003] <= 8'h00;
            ram[10'h3FF] <= 8'hAB;
        end else if (rdy) begin
            if (mem_wr) begin
                if (mem_a[17:16] == 2'b11) io_last <= mem_dout;
                else ram[mem_a[9:0]] <= mem_dout;
            end
            mem_din <= ram[mem_a[9:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic ls, input logic wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic fi, input logic [31:0] ia);
        @(negedge clk);
        ena_from_ls     = ls;
        wr_flag_from_ls = wr;
        size_from_ls    = sz;
        addr_from_ls    = a;
        data_from_ls    = d;
        ena_from_if     = fi;
        addr_from_if    = ia;
        @(posedge clk);
        #1;
        ena_from_ls = 1'b0;
        ena_from_if = 1'b0;
    endtask

    // observe 30 cycles after a start edge; k is the cycle index T+k
    task automatic run(input int io_cyc, input int rb_at, input int fz_at,
                       input int fz_len, output int kl, output int ki,
                       output logic [31:0] dl, output logic [31:0] di,
                       output int nwr, output logic [31:0] a4);
        kl = -1; ki = -1; dl = '0; di = '0; nwr = 0; a4 = '0;
        for (int k = 1; k <= 30; k++) begin
            io_buffer_full = (k <= io_cyc);
            rollback_flag  = (k == rb_at);
            rdy            = !(k >= fz_at && k < fz_at + fz_len);
            @(negedge clk);
            if (ok_to_ls && kl < 0) begin kl = k; dl = data_to_ls; end
            if (ok_to_if && ki < 0) begin ki = k; di = inst_to_if; end
            if (mem_wr) nwr++;
            if (k == 4) a4 = mem_a;
            @(posedge clk);
            #1;
        end
        io_buffer_full = 1'b0;
        rollback_flag  = 1'b0;
        rdy            = 1'b1;
    endtask

    int          kl, ki, nwr;
    logic [31:0] dl, di, a4;

    initial begin
        rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; rollback_flag = 1'b0;
        ena_from_ls = 1'b0; wr_flag_from_ls = 1'b0; size_from_ls = 3'd0;
        addr_from_ls = '0; data_from_ls = '0; ena_from_if = 1'b0;
        addr_from_if = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", 32'({mem_wr, ok_to_ls, ok_to_if}), 32'd0);
        check("rst_a", mem_a, 32'd0);
        check("rst_dout", 32'(mem_dout), 32'd0);
        check("rst_data", data_to_ls | inst_to_if, 32'd0);
        rst = 1'b1;

        issue(1'b1, 1'b0, 3'd4, 32'h100, 32'd0, 1'b0, 32'd0);
        run(0, 0, 0, 0, kl, ki, dl, di, nwr, a4);
        check("lw_lat", 32'(kl), 32'd6);
        check("lw_data", dl, 32'h44332211);
        check("lw_noif", 32'(ki), 32'hFFFFFFFF);

        issue(1'b1, 1'b1, 3'd2, 32'h200, 32'hDEADBEEF, 1'b0, 32'd0);
        run(0, 0, 0, 0, kl, ki, dl, di, nwr, a4);
        check("sh_lat", 32'(kl), 32'd3);
        check("sh_nwr", 32'(nwr), 32'd2);
        check("sh_b0", 32'(ram[10'h200]), 32'hEF);
        check("sh_b1", 32'(ram[10'h201]), 32'hBE);

        issue(1'b1, 1'b1, 3'd1, 32'h30000, 32'h41, 1'b0, 32'd0);
        run(3, 0, 0, 0, kl, ki, dl, di, nwr, a4);
        check("io_lat", 32'(kl), 32'd5);
        check("io_nwr", 32'(nwr), 32'd1);
        check("io_byte", 32'(io_last), 32'h41);

        issue(1'b1, 1'b0, 3'd1, 32'h10, 32'd0, 1'b1, 32'h0);
        run(0, 0, 0, 0, kl, ki, dl, di, nwr, a4);
        check("lb_lat", 32'(kl), 32'd3);
        check("lb_data", dl, 32'h5A);
        check("if_lat", 32'(ki), 32'd9);
        check("if_inst", di, 32'h00500513);

        issue(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 32'h0);
        run(0, 3, 0, 0, kl, ki, dl, di, nwr, a4);
        check("rb_noif", 32'(ki), 32'hFFFFFFFF);
        check("rb_addr", a4, 32'd2);

        issue(1'b1, 1'b0, 3'd1, 32'h100, 32'd0, 1'b0, 32'd0);
        run(0, 0, 0, 0, kl, ki, dl, di, nwr, a4);
        check("post_rb_lat", 32'(kl), 32'd3);
        check("post_rb_data", dl, 32'h11);

        issue(1'b1, 1'b1, 3'd4, 32'h300, 32'h12345678, 1'b0, 32'd0);
        run(0, 2, 0, 0, kl, ki, dl, di, nwr, a4);
        check("sw_rb_lat", 32'(kl), 32'd5);
        check("sw_rb_nwr", 32'(nwr), 32'd4);
        check("sw_rb_word",
              {ram[10'h303], ram[10'h302], ram[10'h301], ram[10'h300]},
              32'h12345678);

        issue(1'b1, 1'b0, 3'd4, 32'h100, 32'd0, 1'b0, 32'd0);
        run(0, 0, 3, 2, kl, ki, dl, di, nwr, a4);
        check("frz_lat", 32'(kl), 32'd8);
        check("frz_data", dl, 32'h44332211);

        issue(1'b1, 1'b0, 3'd2, 32'hFFFFFFFF, 32'd0, 1'b0, 32'd0);
        run(0, 0, 0, 0, kl, ki, dl, di, nwr, a4);
        check("wrap_lat", 32'(kl), 32'd4);
        check("wrap_data", dl, 32'h000013AB);

        issue(1'b1, 1'b0, 3'd4, 32'h100, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_a", mem_a, 32'd0);
        check("mid_rst_data", data_to_ls, 32'd0);
        check("mid_rst_ctl", 32'({mem_wr, ok_to_ls, ok_to_if}), 32'd0);
        rst = 1'b1;
        run(0, 0, 0, 0, kl, ki, dl, di, nwr, a4);
        check("mid_rst_nook", 32'(kl), 32'hFFFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
